// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Two-port round-robin arbiter and transaction sequencer in front of a
//   CPOL=1/CPHA=1 SPI byte engine. A granted requester streams len+1 bytes
//   through the engine while spi_ena stays high, which keeps chip-select low
//   for the whole transaction. Each received byte is routed back to the owner.
//
// Ports
//   clk, arst               system clock, asynchronous active-high reset
//   reqN_valid/len/msb_lsb  request from port N (len = byte count - 1)
//   reqN_tx_data            head of port N's show-ahead TX queue
//   reqN_ready/tx_pop       request accepted / TX head consumed (pulses)
//   reqN_rx_data/rx_valid   last received byte / update pulse
//   reqN_done               transaction finished, CS released (pulse)
//   busy, owner             sequencer active / granted port
//   spi_*                   connection to the SPI byte engine
module spi_txn_arbiter (
  input  logic       clk,
  input  logic       arst,
  input  logic       req0_valid,
  input  logic [3:0] req0_len,
  input  logic       req0_msb_lsb,
  input  logic [7:0] req0_tx_data,
  output logic       req0_ready,
  output logic       req0_tx_pop,
  output logic [7:0] req0_rx_data,
  output logic       req0_rx_valid,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic [3:0] req1_len,
  input  logic       req1_msb_lsb,
  input  logic [7:0] req1_tx_data,
  output logic       req1_ready,
  output logic       req1_tx_pop,
  output logic [7:0] req1_rx_data,
  output logic       req1_rx_valid,
  output logic       req1_done,
  output logic       busy,
  output logic       owner,
  output logic       spi_ena,
  output logic [7:0] spi_byte_2_send,
  output logic       spi_msb_lsb,
  input  logic       spi_end_trans,
  input  logic [7:0] spi_byte_received
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      remaining_q, remaining_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [7:0]      byte_q, byte_d;
  logic            msb_q, msb_d;
  logic            ena_q;
  logic [1:0][7:0] rx_data_q, rx_data_d;
  logic [1:0]      rx_valid_q, rx_valid_d;

  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] pop;
  logic [1:0] done;
  logic       grant;
  logic       grant_idx;
  logic       capture;
  logic       advance;
  logic [7:0] owner_tx_data;

  always_comb begin
    valid = {req1_valid, req0_valid};
    // Gated by arst so no requester sees an acceptance that reset discards.
    grant = (state_q == StIdle) && (valid != 2'b00) && !arst;
    // On contention the port that did not win last time gets the grant.
    grant_idx = (valid == 2'b11) ? ~last_q : valid[1];
    // end_trans outside RUN is ignored entirely.
    capture = (state_q == StRun) && spi_end_trans;
    advance = capture && (remaining_q != 4'd0);
    owner_tx_data = owner_q ? req1_tx_data : req0_tx_data;

    ready = '0;
    pop   = '0;
    done  = '0;
    if (grant) begin
      ready[grant_idx] = 1'b1;
      pop[grant_idx]   = 1'b1;
    end
    if (advance) begin
      pop[owner_q] = 1'b1;
    end
    if (state_q == StDone) begin
      done[owner_q] = 1'b1;
    end

    state_d     = state_q;
    remaining_d = remaining_q;
    owner_d     = owner_q;
    last_d      = last_q;
    byte_d      = byte_q;
    msb_d       = msb_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = '0;

    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d     = StRun;
          byte_d      = grant_idx ? req1_tx_data : req0_tx_data;
          msb_d       = grant_idx ? req1_msb_lsb : req0_msb_lsb;
          remaining_d = grant_idx ? req1_len : req0_len;
          owner_d     = grant_idx;
          last_d      = grant_idx;
        end
      end
      StRun: begin
        if (capture) begin
          // Sample now: the engine clears its RX register once enable drops.
          rx_data_d[owner_q]  = spi_byte_received;
          rx_valid_d[owner_q] = 1'b1;
          if (remaining_q == 4'd0) begin
            state_d = StDone;
          end else begin
            remaining_d = remaining_q - 4'd1;
            byte_d      = owner_tx_data;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= StIdle;
      remaining_q <= 4'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      byte_q      <= 8'd0;
      msb_q       <= 1'b0;
      ena_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      byte_q      <= byte_d;
      msb_q       <= msb_d;
      // Registered copy of "next state is RUN": stays high between bytes.
      ena_q       <= (state_d == StRun);
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign req0_ready      = ready[0];
  assign req1_ready      = ready[1];
  assign req0_tx_pop     = pop[0];
  assign req1_tx_pop     = pop[1];
  assign req0_rx_data    = rx_data_q[0];
  assign req1_rx_data    = rx_data_q[1];
  assign req0_rx_valid   = rx_valid_q[0];
  assign req1_rx_valid   = rx_valid_q[1];
  assign req0_done       = done[0];
  assign req1_done       = done[1];
  assign busy            = (state_q != StIdle);
  assign owner           = owner_q;
  assign spi_ena         = ena_q;
  assign spi_byte_2_send = byte_q;
  assign spi_msb_lsb     = msb_q;

endmodule
